// File: rtl/mac16_unit_pkg.sv
// ----------------------------------------------------------------------------
// mac16_unit_pkg
//   Shared definitions for the mac16_unit MAC slice:
//     - FSM state encodings (MAC_IDLE / MAC_RUN / MAC_DONE)
//     - MAC_CYCLES : number of RUN cycles per multiply (one multiplier bit each)
//     - ACC_W_DEF  : accumulator width (the only supported value is 32)
//     - mag17()    : 17-bit magnitude of a signed 16-bit operand
// ----------------------------------------------------------------------------
package mac16_unit_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_RUN  = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_e;

  localparam int MAC_CYCLES = 16;
  localparam int ACC_W_DEF  = 32;

  // 17 bits are needed so that -32768 (16'h8000) maps to +32768 without wrap.
  function automatic logic [16:0] mag17(input logic [15:0] v);
    logic [16:0] ext;
    ext = {v[15], v};
    return v[15] ? (~ext + 17'd1) : ext;
  endfunction

endpackage

// File: rtl/mac16_seq_mult.sv
// ----------------------------------------------------------------------------
// mac16_seq_mult
//   Iterative unsigned 17x17 shift-add multiplier core, one multiplier bit per
//   step. Operand magnitudes never exceed 2^15, so the product fits 32 bits.
//
//   Ports
//     clk     in   1   rising-edge clock
//     rst     in   1   synchronous, active-high reset
//     load    in   1   capture mcand/mplier and clear the partial product
//     mcand   in   17  unsigned multiplicand magnitude
//     mplier  in   17  unsigned multiplier magnitude
//     step    in   1   consume one multiplier bit
//     product out  32  partial product INCLUDING the bit currently being
//                      consumed; after the 16th step is presented it is the
//                      full product, so the caller can use it on that same edge
// ----------------------------------------------------------------------------
module mac16_seq_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [16:0] mcand,
  input  logic [16:0] mplier,
  input  logic        step,
  output logic [31:0] product
);

  logic [31:0] mc_q;
  logic [16:0] mp_q;
  logic [31:0] prod_q;

  // Look-ahead product: the running sum plus the current bit's contribution.
  assign product = prod_q + (mp_q[0] ? mc_q : 32'd0);

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_q   <= '0;
      mp_q   <= '0;
      prod_q <= '0;
    end else if (load) begin
      mc_q   <= {15'd0, mcand};
      mp_q   <= mplier;
      prod_q <= '0;
    end else if (step) begin
      prod_q <= product;
      mc_q   <= mc_q << 1;
      mp_q   <= mp_q >> 1;
    end
  end

endmodule

// File: rtl/mac16_unit.sv
// ----------------------------------------------------------------------------
// mac16_unit
//   Multi-cycle signed 16x16 multiply-accumulate unit. Each accepted start
//   runs 16 RUN cycles of shift-add, then adds the signed product into a
//   32-bit wrapping accumulator and narrows it to a 16-bit result.
//
//   Build option: define MAC16_SATURATE_EN to clamp the narrowed result to
//   [-32768, 32767]; otherwise the result is the low 16 bits (truncation).
//
//   Parameters
//     FRAC_BITS  arithmetic right shift applied before narrowing (0..16)
//     ACC_W      accumulator width; only 32 is supported
//
//   Ports
//     clk        in   1   rising-edge clock
//     rst        in   1   synchronous, active-high reset (aborts a RUN)
//     start      in   1   launch a MAC; honoured in IDLE or DONE only
//     clear_acc  in   1   with start: 1 = seed accumulator with 0
//     op_a       in   16  signed multiplicand, captured on accepted start
//     op_b       in   16  signed multiplier, captured on accepted start
//     busy       out  1   high while in RUN
//     done       out  1   one-cycle pulse; result/acc_out freshly updated
//     result     out  16  narrowed accumulator, held until the next done
//     acc_out    out  32  full accumulator value
// ----------------------------------------------------------------------------
module mac16_unit
  import mac16_unit_pkg::*;
#(
  parameter int FRAC_BITS = 0,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear_acc,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output logic [ACC_W-1:0] acc_out
);

  mac_state_e       state_q, state_d;
  logic [3:0]       cnt_q;
  logic             neg_q;
  logic             clr_q;
  logic [ACC_W-1:0] acc_q;
  logic [15:0]      result_q;

  logic             accept;
  logic             last_run;
  logic [31:0]      product;
  logic [ACC_W-1:0] signed_prod;
  logic [ACC_W-1:0] acc_d;
  logic [15:0]      narrow;

  assign accept   = start && (state_q != MAC_RUN);
  assign last_run = (state_q == MAC_RUN) && (cnt_q == 4'(MAC_CYCLES - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= MAC_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      MAC_IDLE: if (start) state_d = MAC_RUN;
      MAC_RUN: begin
        busy = 1'b1;
        if (last_run) state_d = MAC_DONE;
      end
      MAC_DONE: begin
        done    = 1'b1;
        state_d = start ? MAC_RUN : MAC_IDLE;
      end
      default: state_d = MAC_IDLE;
    endcase
  end

  // ---------------- multiplier core ----------------
  mac16_seq_mult u_mult (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .mcand   (mag17(op_a)),
    .mplier  (mag17(op_b)),
    .step    (state_q == MAC_RUN),
    .product (product)
  );

  // ---------------- accumulate and narrow ----------------
  assign signed_prod = neg_q ? (~product + 32'd1) : product;
  assign acc_d       = (clr_q ? '0 : acc_q) + signed_prod;

`ifdef MAC16_SATURATE_EN
  logic signed [ACC_W-1:0] shifted;
  assign shifted = $signed(acc_d) >>> FRAC_BITS;
  always_comb begin
    if (shifted > $signed(ACC_W'(32767)))        narrow = 16'h7FFF;
    else if (shifted < -$signed(ACC_W'(32768)))  narrow = 16'h8000;
    else                                         narrow = shifted[15:0];
  end
`else
  assign narrow = 16'($signed(acc_d) >>> FRAC_BITS);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      clr_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        neg_q <= op_a[15] ^ op_b[15];
        clr_q <= clear_acc;
        cnt_q <= '0;
      end else if (state_q == MAC_RUN) begin
        cnt_q <= cnt_q + 4'd1;
      end
      // Product is complete on the edge that leaves RUN.
      if (last_run) begin
        acc_q    <= acc_d;
        result_q <= narrow;
      end
    end
  end

  assign acc_out = acc_q;
  assign result  = result_q;

endmodule

// File: tb/tb_mac16_unit.sv
// ----------------------------------------------------------------------------
// tb_mac16_unit
//   Directed self-checking bench for mac16_unit (FRAC_BITS = 0). Inputs are
//   driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mac16_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear_acc;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [31:0] acc_out;

  int checks = 0;
  int errors = 0;

  // Observations from the last run_mac call.
  int          lat;
  int          busy_bad;
  logic [31:0] acc_obs;
  logic [15:0] res_obs;

  mac16_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear_acc (clear_acc),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  // Called at a falling edge. Launches one MAC, scrambles the operands during
  // RUN, optionally re-pulses start at RUN cycle inj, and returns at the
  // falling edge of the done cycle (lat = cycles from accept, 0 = timeout).
  task automatic run_mac(input logic [15:0] a, input logic [15:0] b,
                         input logic clr, input int inj);
    int cnt;
    start = 1'b1; op_a = a; op_b = b; clear_acc = clr;
    lat = 0; busy_bad = 0; acc_obs = 'x; res_obs = 'x;
    @(negedge clk);
    cnt = 1;
    start = 1'b0; op_a = 16'h5A5A; op_b = 16'hA5A5; clear_acc = ~clr;
    while (cnt <= 40) begin
      if (done === 1'b1) begin
        lat = cnt; acc_obs = acc_out; res_obs = result;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      start = (cnt == inj);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear_acc = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done});
    end
    checks++;
    if (result !== 16'h0000) begin
      errors++; $display("FAIL reset_result: got %h expected 0000", result);
    end
    checks++;
    if (acc_out !== 32'h0) begin
      errors++; $display("FAIL reset_acc: got %h expected 00000000", acc_out);
    end
    @(negedge clk);
  endtask

  task automatic test_mac_basic();
    // 3 * -4 = -12
    run_mac(16'd3, 16'hFFFC, 1'b1, 0);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL t2_latency: got %0d expected 17", lat);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++; $display("FAIL t2_busy: %0d RUN cycles without busy, expected 0", busy_bad);
    end
    checks++;
    if (acc_obs !== 32'hFFFFFFF4) begin
      errors++; $display("FAIL t2_acc: got %h expected FFFFFFF4", acc_obs);
    end
    checks++;
    if (res_obs !== 16'hFFF4) begin
      errors++; $display("FAIL t2_result: got %h expected FFF4", res_obs);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL t2_idle_after: busy/done=%b expected 00", {busy, done});
    end
    checks++;
    if (result !== 16'hFFF4) begin
      errors++; $display("FAIL t2_result_held: got %h expected FFF4", result);
    end
  endtask

  task automatic test_accumulate();
    // -12 + 100*200 = 19988
    run_mac(16'd100, 16'd200, 1'b0, 0);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL t3_latency: got %0d expected 17", lat);
    end
    checks++;
    if (acc_obs !== 32'h00004E14) begin
      errors++; $display("FAIL t3_acc: got %h expected 00004E14", acc_obs);
    end
    checks++;
    if (res_obs !== 16'h4E14) begin
      errors++; $display("FAIL t3_result: got %h expected 4E14", res_obs);
    end
    @(negedge clk);
  endtask

  task automatic test_max_positive();
    logic [15:0] exp_res;
`ifdef MAC16_SATURATE_EN
    exp_res = 16'h7FFF;
`else
    exp_res = 16'h0001;
`endif
    run_mac(16'h7FFF, 16'h7FFF, 1'b1, 0);
    checks++;
    if (acc_obs !== 32'h3FFF0001) begin
      errors++; $display("FAIL t4_acc: got %h expected 3FFF0001", acc_obs);
    end
    checks++;
    if (res_obs !== exp_res) begin
      errors++; $display("FAIL t4_result: got %h expected %h", res_obs, exp_res);
    end
    @(negedge clk);
  endtask

  task automatic test_min_and_start_in_run();
    logic [15:0] exp_res;
    int extra_done;
`ifdef MAC16_SATURATE_EN
    exp_res = 16'h7FFF;
`else
    exp_res = 16'h0000;
`endif
    run_mac(16'h8000, 16'h8000, 1'b1, 5);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL t5_latency: got %0d expected 17", lat);
    end
    checks++;
    if (acc_obs !== 32'h40000000) begin
      errors++; $display("FAIL t5_acc: got %h expected 40000000", acc_obs);
    end
    checks++;
    if (res_obs !== exp_res) begin
      errors++; $display("FAIL t5_result: got %h expected %h", res_obs, exp_res);
    end
    extra_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin
      errors++; $display("FAIL t5_single_done: %0d busy/done cycles after done, expected 0", extra_done);
    end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    start = 1'b1; op_a = 16'd1000; op_b = 16'd1000; clear_acc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);  // now in RUN cycle 8
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL t6_busy_before: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL t6_abort_flags: busy/done=%b expected 00", {busy, done});
    end
    checks++;
    if (acc_out !== 32'h0 || result !== 16'h0) begin
      errors++; $display("FAIL t6_abort_clear: acc=%h result=%h expected 0/0", acc_out, result);
    end
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++; $display("FAIL t6_no_done: %0d done pulses, expected 0", seen_done);
    end
    // 5 * -7 = -35
    run_mac(16'd5, 16'hFFF9, 1'b0, 0);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL t6_fresh_latency: got %0d expected 17", lat);
    end
    checks++;
    if (acc_obs !== 32'hFFFFFFDD || res_obs !== 16'hFFDD) begin
      errors++; $display("FAIL t6_fresh_value: acc=%h result=%h expected FFFFFFDD/FFDD", acc_obs, res_obs);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    // (-1)*(-1) = 1, then start again in the DONE cycle: 1 + (-32768)*1
    run_mac(16'hFFFF, 16'hFFFF, 1'b1, 0);
    checks++;
    if (acc_obs !== 32'h00000001) begin
      errors++; $display("FAIL b2b_first_acc: got %h expected 00000001", acc_obs);
    end
    run_mac(16'h8000, 16'h0001, 1'b0, 0);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL b2b_period: got %0d expected 17", lat);
    end
    checks++;
    if (acc_obs !== 32'hFFFF8001 || res_obs !== 16'h8001) begin
      errors++; $display("FAIL b2b_second_value: acc=%h result=%h expected FFFF8001/8001", acc_obs, res_obs);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mac_basic();
    test_accumulate();
    test_max_positive();
    test_min_and_start_in_run();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
